mem_wb_pipe: RTL and testbench
==============================

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of MemRes/ALURes/wb_data paths.
REQ-002 Parameter REG_W, default 5, width of destination register index.
REQ-003 Parameter STAGES, default 1, number of register stages between MEM and WB; legal range 1..4.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold all stages.
REQ-007 flush  input  1  invalidate all stages.
REQ-008 in_valid  input  1  MEM-stage entry carries a real instruction.
REQ-009 RegWrite_in  input  1; MemToReg_in  input  1  MEM-stage control bits.
REQ-010 MemRes_in  input  DATA_W; ALURes_in  input  DATA_W  MEM-stage data.
REQ-011 WREG_in  input  REG_W  MEM-stage destination register.
REQ-012 out_valid, RegWrite_out, MemToReg_out  output  1 each  last-stage control.
REQ-013 MemRes_out, ALURes_out  output  DATA_W; WREG_out  output  REG_W  last-stage data.
REQ-014 wb_we  output  1  register-file write enable.
REQ-015 wb_data  output  DATA_W  register-file write data.
REQ-016 bubble_cnt  output  16  count of cycles with out_valid=0.

Function
REQ-017 Block SHALL hold a chain of STAGES entries {valid, RegWrite, MemToReg, MemRes, ALURes, WREG}; outputs SHALL be driven directly from the last entry.
REQ-018 Advance (rst=0, flush=0, stall=0): entry0 <= inputs, entry k <= entry k-1; latency input-to-output SHALL be exactly STAGES cycles.
REQ-019 in_valid=0 on advance: entry0 valid=0 and RegWrite=0; data fields captured as presented.
REQ-020 Stored RegWrite SHALL be 0 whenever stored valid is 0.
REQ-021 stall=1 (flush=0): every entry SHALL hold its value.
REQ-022 flush=1: every entry SHALL become valid=0, RegWrite=0, MemToReg=0, data=0, WREG=0 on next edge; flush SHALL win over stall; inputs that cycle are discarded.
REQ-023 wb_we SHALL equal out_valid AND RegWrite_out AND (WREG_out != 0); writes to register 0 suppressed.
REQ-024 bubble_cnt SHALL increment by 1 on each edge where rst=0 and out_valid=0 (pre-edge value), saturate at 0xFFFF, and keep counting during stall.
REQ-025 STAGES outside 1..4 SHALL cause an elaboration-time error.
REQ-026 No combinational path from any input to any output except wb_data/wb_we from last-stage registers.

Reset
REQ-027 rst=1 on an edge SHALL clear all entries (all fields 0) and bubble_cnt to 0, overriding stall and flush.
REQ-028 After reset, out_valid, RegWrite_out, MemToReg_out, wb_we SHALL be 0, MemRes_out, ALURes_out, wb_data 0, WREG_out 0, until a valid entry reaches the last stage.
REQ-029 Reset mid-stream SHALL discard all in-flight entries; none SHALL reach the outputs afterwards.

Configuration
REQ-030 Macro MEM_WB_WBMUX_EN defined: wb_data SHALL equal MemToReg_out ? MemRes_out : ALURes_out.
REQ-031 MEM_WB_WBMUX_EN undefined: mux logic SHALL be absent and wb_data SHALL be constant 0; wb_we and all other behaviour unchanged.

Verification
REQ-032 STAGES=1, reset then in_valid=1, RegWrite=1, MemToReg=0, ALURes=0x0000_1234, WREG=5 -> next cycle out_valid=1, wb_we=1, wb_data=0x0000_1234 (macro on).
REQ-033 STAGES=3, four consecutive valid entries WREG=1,2,3,4 -> outputs appear on cycles 3,4,5,6 after first input, in order.
REQ-034 STAGES=2, stall=1 for 3 cycles with entries in flight -> outputs constant for 3 cycles, then resume with no loss or duplication.
REQ-035 STAGES=2, stall=1 and flush=1 same cycle with two valid entries -> both entries removed, out_valid=0 for next 2 cycles, WREG_out=0.
REQ-036 Valid entry RegWrite=1, WREG=0, MemToReg=1, MemRes=0xDEAD_BEEF -> out_valid=1, wb_we=0, wb_data=0xDEAD_BEEF.
REQ-037 Hold in_valid=0 for 70000 cycles after reset -> bubble_cnt reaches and stays 0xFFFF; rst=1 -> bubble_cnt=0 next cycle.

Source files
------------

// File: rtl/mem_wb_if.sv
// MEM->WB pipeline bus: MEM-stage entry, stall/flush controls, last-stage outputs
// and write-back port. The master drives the MEM side; the pipe is the slave.
interface mem_wb_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   logic              stall;
   logic              flush;
   logic              in_valid;
   logic              RegWrite_in;
   logic              MemToReg_in;
   logic [DATA_W-1:0] MemRes_in;
   logic [DATA_W-1:0] ALURes_in;
   logic [REG_W-1:0]  WREG_in;
   logic              out_valid;
   logic              RegWrite_out;
   logic              MemToReg_out;
   logic [DATA_W-1:0] MemRes_out;
   logic [DATA_W-1:0] ALURes_out;
   logic [REG_W-1:0]  WREG_out;
   logic              wb_we;
   logic [DATA_W-1:0] wb_data;
   logic [15:0]       bubble_cnt;

   modport master (
      output stall, flush, in_valid, RegWrite_in, MemToReg_in, MemRes_in, ALURes_in, WREG_in,
      input  out_valid, RegWrite_out, MemToReg_out, MemRes_out, ALURes_out, WREG_out,
             wb_we, wb_data, bubble_cnt
   );
   modport slave (
      input  stall, flush, in_valid, RegWrite_in, MemToReg_in, MemRes_in, ALURes_in, WREG_in,
      output out_valid, RegWrite_out, MemToReg_out, MemRes_out, ALURes_out, WREG_out,
             wb_we, wb_data, bubble_cnt
   );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB register chain of STAGES entries with stall/flush, write-back enable and bubble counter.
// Define MEM_WB_WBMUX_EN to build the MemToReg write-back data mux; otherwise wb_data is tied to 0.
module mem_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int STAGES = 1
) (
   input logic    clk,
   input logic    rst,
   mem_wb_if.slave bus
);
   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("mem_wb_pipe: STAGES must be in 1..4");
   end

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_to_reg;
      logic [DATA_W-1:0] mem_res;
      logic [DATA_W-1:0] alu_res;
      logic [REG_W-1:0]  wreg;
   } entry_t;

   entry_t      entry_q [STAGES];
   entry_t      entry_d [STAGES];
   logic [15:0] bubble_cnt_q, bubble_cnt_d;
   entry_t      last;

   always_comb begin
      for (int k = 0; k < STAGES; k++) entry_d[k] = entry_q[k];
      if (bus.flush) begin
         for (int k = 0; k < STAGES; k++) entry_d[k] = '0;
      end else if (!bus.stall) begin
         // RegWrite is masked with valid so a bubble can never write the register file
         entry_d[0].valid      = bus.in_valid;
         entry_d[0].reg_write  = bus.in_valid & bus.RegWrite_in;
         entry_d[0].mem_to_reg = bus.MemToReg_in;
         entry_d[0].mem_res    = bus.MemRes_in;
         entry_d[0].alu_res    = bus.ALURes_in;
         entry_d[0].wreg       = bus.WREG_in;
         for (int k = 1; k < STAGES; k++) entry_d[k] = entry_q[k-1];
      end
   end

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (!last.valid && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) entry_q[k] <= '0;
         bubble_cnt_q <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) entry_q[k] <= entry_d[k];
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign last             = entry_q[STAGES-1];
   assign bus.out_valid    = last.valid;
   assign bus.RegWrite_out = last.reg_write;
   assign bus.MemToReg_out = last.mem_to_reg;
   assign bus.MemRes_out   = last.mem_res;
   assign bus.ALURes_out   = last.alu_res;
   assign bus.WREG_out     = last.wreg;
   assign bus.wb_we        = last.valid & last.reg_write & (last.wreg != '0);
   assign bus.bubble_cnt   = bubble_cnt_q;
`ifdef MEM_WB_WBMUX_EN
   assign bus.wb_data      = last.mem_to_reg ? last.mem_res : last.alu_res;
`else
   assign bus.wb_data      = '0;
`endif
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench: three pipes (STAGES=1,2,3) share one stimulus; each step checks the
// instance the scenario targets against hand-computed values.
module tb_mem_wb_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mem_wb_if #(.DATA_W(32), .REG_W(5)) i1 ();
   mem_wb_if #(.DATA_W(32), .REG_W(5)) i2 ();
   mem_wb_if #(.DATA_W(32), .REG_W(5)) i3 ();

   mem_wb_pipe #(.DATA_W(32), .REG_W(5), .STAGES(1)) d1 (.clk(clk), .rst(rst), .bus(i1));
   mem_wb_pipe #(.DATA_W(32), .REG_W(5), .STAGES(2)) d2 (.clk(clk), .rst(rst), .bus(i2));
   mem_wb_pipe #(.DATA_W(32), .REG_W(5), .STAGES(3)) d3 (.clk(clk), .rst(rst), .bus(i3));

   function automatic logic [31:0] wbx(input logic mtr, input logic [31:0] mem, input logic [31:0] alu);
`ifdef MEM_WB_WBMUX_EN
      return mtr ? mem : alu;
`else
      return 32'h0;
`endif
   endfunction

   task automatic drive(input logic st, input logic fl, input logic v, input logic rw, input logic mtr,
                        input logic [31:0] mem, input logic [31:0] alu, input logic [4:0] wr);
      i1.stall = st; i1.flush = fl; i1.in_valid = v; i1.RegWrite_in = rw; i1.MemToReg_in = mtr;
      i1.MemRes_in = mem; i1.ALURes_in = alu; i1.WREG_in = wr;
      i2.stall = st; i2.flush = fl; i2.in_valid = v; i2.RegWrite_in = rw; i2.MemToReg_in = mtr;
      i2.MemRes_in = mem; i2.ALURes_in = alu; i2.WREG_in = wr;
      i3.stall = st; i3.flush = fl; i3.in_valid = v; i3.RegWrite_in = rw; i3.MemToReg_in = mtr;
      i3.MemRes_in = mem; i3.ALURes_in = alu; i3.WREG_in = wr;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      tick();
      do_reset();

      // reset state
      chk("rst_valid1", i1.out_valid, 1'b0);
      chk("rst_we1", i1.wb_we, 1'b0);
      chk("rst_rw3", i3.RegWrite_out, 1'b0);
      chk("rst_mtr3", i3.MemToReg_out, 1'b0);
      chk("rst_wreg3", i3.WREG_out, 5'd0);
      chk("rst_alu3", i3.ALURes_out, 32'h0);
      chk("rst_mem3", i3.MemRes_out, 32'h0);
      chk("rst_wbdata3", i3.wb_data, 32'h0);
      chk("rst_bcnt", i1.bubble_cnt, 16'd0);

      // single-stage basic write-back
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5);
      tick();
      idle();
      chk("s1_valid", i1.out_valid, 1'b1);
      chk("s1_we", i1.wb_we, 1'b1);
      chk("s1_wreg", i1.WREG_out, 5'd5);
      chk("s1_wbdata", i1.wb_data, wbx(1'b0, 32'h0, 32'h0000_1234));
      chk("s2_not_yet", i2.out_valid, 1'b0);
      tick();
      chk("s2_arrive", i2.WREG_out, 5'd5);
      chk("s1_gone", i1.out_valid, 1'b0);

      // write to r0 suppressed, MemToReg selects MemRes
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0077, 5'd0);
      tick();
      idle();
      chk("r0_valid", i1.out_valid, 1'b1);
      chk("r0_rw", i1.RegWrite_out, 1'b1);
      chk("r0_we", i1.wb_we, 1'b0);
      chk("r0_mem", i1.MemRes_out, 32'hDEAD_BEEF);
      chk("r0_wbdata", i1.wb_data, wbx(1'b1, 32'hDEAD_BEEF, 32'h0000_0077));

      // bubble: RegWrite forced low, data captured as presented
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0055, 32'h0000_0066, 5'd9);
      tick();
      idle();
      chk("bub_valid", i1.out_valid, 1'b0);
      chk("bub_rw", i1.RegWrite_out, 1'b0);
      chk("bub_we", i1.wb_we, 1'b0);
      chk("bub_mem", i1.MemRes_out, 32'h0000_0055);
      chk("bub_wreg", i1.WREG_out, 5'd9);

      // three-stage ordering and latency
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i < 4) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'(i + 100), 5'(i + 1));
         else idle();
         tick();
         if (i + 1 >= 3 && i + 1 <= 6) begin
            chk("s3_valid", i3.out_valid, 1'b1);
            chk("s3_wreg", i3.WREG_out, 5'(i - 1));
            chk("s3_alu", i3.ALURes_out, 32'(i + 98));
         end else begin
            chk("s3_idle", i3.out_valid, 1'b0);
         end
      end

      // two-stage stall: hold for 3 edges, then resume in order
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd11, 5'd1);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd22, 5'd2);
      tick();
      chk("st_pre", i2.WREG_out, 5'd1);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd33, 5'd3);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_hold_wreg", i2.WREG_out, 5'd1);
         chk("st_hold_alu", i2.ALURes_out, 32'd11);
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd33, 5'd3);
      tick();
      chk("st_res_b", i2.WREG_out, 5'd2);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd44, 5'd4);
      tick();
      chk("st_res_c", i2.WREG_out, 5'd3);
      idle();
      tick();
      chk("st_res_d", i2.WREG_out, 5'd4);
      chk("st_res_dv", i2.out_valid, 1'b1);
      tick();
      chk("st_drain", i2.out_valid, 1'b0);

      // flush wins over stall and discards that cycle's input
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd11, 5'd1);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd22, 5'd2);
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'd77, 5'd7);
      tick();
      idle();
      chk("fl_valid0", i2.out_valid, 1'b0);
      chk("fl_wreg0", i2.WREG_out, 5'd0);
      chk("fl_alu0", i2.ALURes_out, 32'h0);
      chk("fl_mtr0", i2.MemToReg_out, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("fl_valid", i2.out_valid, 1'b0);
         chk("fl_wreg", i2.WREG_out, 5'd0);
      end

      // reset mid-stream overrides stall and discards in-flight entries
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd1, 5'd1);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd2, 5'd2);
      tick();
      rst = 1'b1;
      i3.stall = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      for (int i = 0; i < 3; i++) begin
         chk("mrst_valid", i3.out_valid, 1'b0);
         tick();
      end

      // bubble counter: counts idle edges, keeps counting while stalled
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      chk("bc_5", i1.bubble_cnt, 16'd5);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      tick();
      tick();
      chk("bc_stall", i1.bubble_cnt, 16'd7);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd5, 5'd3);
      tick();
      idle();
      chk("bc_8", i1.bubble_cnt, 16'd8);
      tick();
      chk("bc_hold", i1.bubble_cnt, 16'd8);

      // saturation then reset clears
      do_reset();
      for (int i = 0; i < 70000; i++) tick();
      chk("bc_sat", i1.bubble_cnt, 16'hFFFF);
      tick();
      chk("bc_sat_hold", i1.bubble_cnt, 16'hFFFF);
      rst = 1'b1;
      tick();
      chk("bc_rst", i1.bubble_cnt, 16'd0);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
